// File: rtl/veri_bellegi_yanitlayici.sv
// Data-port scratchpad RAM responder: one outstanding request, byte-masked writes, reads after GECIKME cycles.
// Optional macro VERI_BELLEGI_ADRES_DENETIM_EN: out-of-range requests are flagged and read back 32'hDEAD_BEEF instead of wrapping.
module veri_bellegi_yanitlayici #(
  parameter int                   ADRES_BIT   = 32,
  parameter int                   VERI_BIT    = 32,
  parameter int                   VERI_BYTE   = VERI_BIT / 8,
  parameter int                   SATIR       = 1024,
  parameter logic [ADRES_BIT-1:0] TABAN_ADRES = 32'h4000_0000,
  parameter int                   GECIKME     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADRES_BIT-1:0] port_istek_adres_i,
  input  logic                 port_istek_gecerli_i,
  input  logic                 port_istek_onbellekleme_i,
  input  logic                 port_istek_yaz_i,
  input  logic [VERI_BIT-1:0]  port_istek_veri_i,
  input  logic [VERI_BYTE-1:0] port_istek_maske_i,
  output logic                 port_istek_hazir_o,
  output logic [VERI_BIT-1:0]  port_veri_o,
  output logic                 port_veri_gecerli_o,
  input  logic                 port_veri_hazir_i,
  output logic                 adres_hata_o
);

  localparam int INDEKS_BIT = $clog2(SATIR);

  typedef enum logic [1:0] {BOS, SAY, YANIT} durum_t;

  durum_t                r_durum;
  logic [3:0]            r_sayac;
  logic [VERI_BIT-1:0]   r_veri;
  logic                  r_gecerli;
  logic                  r_hazir;
  logic [INDEKS_BIT-1:0] r_indeks;
  logic                  r_disarida;
  logic [VERI_BIT-1:0]   r_mem [SATIR];

  logic                  w_kabul;
  logic [ADRES_BIT-1:0]  w_ofset;
  logic [INDEKS_BIT-1:0] w_indeks;
  logic                  w_disarida;
  logic [INDEKS_BIT-1:0] w_oku_indeks;
  logic                  w_oku_disarida;
  logic [VERI_BIT-1:0]   w_oku_veri;
  logic                  w_yaz;
  logic                  w_unused;

  assign w_kabul  = port_istek_gecerli_i && r_hazir;
  assign w_ofset  = port_istek_adres_i - TABAN_ADRES;
  assign w_indeks = w_ofset[INDEKS_BIT+1:2];
  assign w_unused = ^{port_istek_onbellekleme_i, w_ofset};

`ifdef VERI_BELLEGI_ADRES_DENETIM_EN
  // Addresses below the base wrap to a huge offset, so one unsigned compare covers both ends.
  assign w_disarida = (w_ofset >= ADRES_BIT'(4 * SATIR));

  logic r_hata;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_hata <= 1'b0;
    else       r_hata <= w_kabul && w_disarida;
  end
  assign adres_hata_o = r_hata;
`else
  assign w_disarida   = 1'b0;
  assign adres_hata_o = 1'b0;
`endif

  // With GECIKME==1 the data is loaded at the accept edge, so use the live request fields.
  assign w_oku_indeks   = (r_durum == BOS) ? w_indeks   : r_indeks;
  assign w_oku_disarida = (r_durum == BOS) ? w_disarida : r_disarida;
  assign w_oku_veri     = w_oku_disarida ? VERI_BIT'(32'hDEAD_BEEF) : r_mem[w_oku_indeks];
  assign w_yaz          = w_kabul && port_istek_yaz_i && !w_disarida;

  always_ff @(posedge clk_i) begin
    if (w_yaz) begin
      for (int b = 0; b < VERI_BYTE; b++) begin
        if (port_istek_maske_i[b]) r_mem[w_indeks][8*b +: 8] <= port_istek_veri_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum    <= BOS;
      r_sayac    <= 4'd0;
      r_veri     <= '0;
      r_gecerli  <= 1'b0;
      r_hazir    <= 1'b1;
      r_indeks   <= '0;
      r_disarida <= 1'b0;
    end else begin
      case (r_durum)
        BOS: begin
          if (w_kabul && !port_istek_yaz_i) begin
            r_indeks   <= w_indeks;
            r_disarida <= w_disarida;
            r_hazir    <= 1'b0;
            if (GECIKME == 1) begin
              r_durum   <= YANIT;
              r_veri    <= w_oku_veri;
              r_gecerli <= 1'b1;
            end else begin
              r_durum <= SAY;
              r_sayac <= 4'(GECIKME - 1);
            end
          end
        end
        SAY: begin
          if (r_sayac == 4'd1) begin
            r_durum   <= YANIT;
            r_sayac   <= 4'd0;
            r_veri    <= w_oku_veri;
            r_gecerli <= 1'b1;
          end else begin
            r_sayac <= r_sayac - 4'd1;
          end
        end
        YANIT: begin
          if (port_veri_hazir_i) begin
            r_durum   <= BOS;
            r_gecerli <= 1'b0;
            r_hazir   <= 1'b1;
          end
        end
        default: r_durum <= BOS;
      endcase
    end
  end

  assign port_istek_hazir_o  = r_hazir;
  assign port_veri_o         = r_veri;
  assign port_veri_gecerli_o = r_gecerli;

endmodule

// File: tb/tb_veri_bellegi_yanitlayici.sv
// Directed bench: instance A uses GECIKME=2, instance B uses GECIKME=1; both share the request bus.
module tb_veri_bellegi_yanitlayici;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adres;
  logic        onb;
  logic        yaz;
  logic [31:0] veri;
  logic [3:0]  maske;
  logic        hazir_i;
  logic        a_gec, b_gec;
  logic        a_hazir, b_hazir, a_vgec, b_vgec, a_hata, b_hata;
  logic [31:0] a_veri, b_veri;
  logic        sec;
  logic        s_hazir, s_vgec;
  logic [31:0] s_veri;

  int n_kontrol = 0;
  int n_gecen   = 0;
  int n_darbe   = 0;

  always #5 clk = ~clk;

  veri_bellegi_yanitlayici #(.GECIKME(2)) u_a (
    .clk_i(clk), .rst_i(rst),
    .port_istek_adres_i(adres), .port_istek_gecerli_i(a_gec),
    .port_istek_onbellekleme_i(onb), .port_istek_yaz_i(yaz),
    .port_istek_veri_i(veri), .port_istek_maske_i(maske),
    .port_istek_hazir_o(a_hazir), .port_veri_o(a_veri),
    .port_veri_gecerli_o(a_vgec), .port_veri_hazir_i(hazir_i),
    .adres_hata_o(a_hata)
  );

  veri_bellegi_yanitlayici #(.GECIKME(1)) u_b (
    .clk_i(clk), .rst_i(rst),
    .port_istek_adres_i(adres), .port_istek_gecerli_i(b_gec),
    .port_istek_onbellekleme_i(onb), .port_istek_yaz_i(yaz),
    .port_istek_veri_i(veri), .port_istek_maske_i(maske),
    .port_istek_hazir_o(b_hazir), .port_veri_o(b_veri),
    .port_veri_gecerli_o(b_vgec), .port_veri_hazir_i(hazir_i),
    .adres_hata_o(b_hata)
  );

  assign s_hazir = sec ? b_hazir : a_hazir;
  assign s_vgec  = sec ? b_vgec  : a_vgec;
  assign s_veri  = sec ? b_veri  : a_veri;

  always @(negedge clk) if (a_hata) n_darbe++;

  task automatic kontrol(input string etiket, input logic [31:0] goz, input logic [31:0] bek);
    n_kontrol++;
    if (goz === bek) n_gecen++;
    else $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, goz, bek);
  endtask

  task automatic gec_ayarla(input logic v);
    if (sec) b_gec = v;
    else     a_gec = v;
  endtask

  task automatic yaz_t(input logic [31:0] ad, input logic [31:0] dt, input logic [3:0] m);
    adres = ad; veri = dt; maske = m; yaz = 1'b1; onb = 1'b1;
    gec_ayarla(1'b1);
    @(posedge clk); #1;
    gec_ayarla(1'b0); yaz = 1'b0; onb = 1'b0;
  endtask

  // bulunan = i means valid is sampled high at the i-th edge after the accept edge.
  task automatic oku_t(input string etiket, input logic [31:0] ad, input logic [31:0] bek_veri,
                       input int bek_gecikme, input int n_dur);
    int          bulunan;
    logic [31:0] ilk;
    logic        stabil;
    adres = ad; yaz = 1'b0; hazir_i = 1'b1;
    gec_ayarla(1'b1);
    @(posedge clk); #1;
    gec_ayarla(1'b0);
    if (n_dur > 0) hazir_i = 1'b0;
    bulunan = 0;
    for (int i = 1; i <= 40 && bulunan == 0; i++) begin
      @(negedge clk);
      if (s_vgec) bulunan = i;
    end
    kontrol({etiket, "_gecikme"}, bulunan, bek_gecikme);
    kontrol({etiket, "_veri"}, s_veri, bek_veri);
    kontrol({etiket, "_hazir_dusuk"}, 32'(s_hazir), 0);
    ilk = s_veri;
    stabil = 1'b1;
    for (int j = 0; j < n_dur; j++) begin
      @(negedge clk);
      if (!(s_vgec && s_veri == ilk && !s_hazir)) stabil = 1'b0;
    end
    if (n_dur > 0) begin
      kontrol({etiket, "_bekleme_stabil"}, 32'(stabil), 1);
      hazir_i = 1'b1;
    end
    @(negedge clk);
    kontrol({etiket, "_hazir_geri"}, 32'(s_hazir), 1);
    kontrol({etiket, "_gecerli_dustu"}, 32'(s_vgec), 0);
    kontrol({etiket, "_veri_tutuldu"}, s_veri, bek_veri);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   bas;
    int   gorulen;
    rst = 1'b1; adres = '0; onb = 1'b0; yaz = 1'b0; veri = '0; maske = '0;
    hazir_i = 1'b1; a_gec = 1'b0; b_gec = 1'b0; sec = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    kontrol("reset_hazir", 32'(a_hazir), 1);
    kontrol("reset_gecerli", 32'(a_vgec), 0);
    kontrol("reset_veri", a_veri, 0);
    kontrol("reset_hata", 32'(a_hata), 0);
    kontrol("reset_b_hazir", 32'(b_hazir), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full write and read-back, latency 2
    yaz_t(32'h4000_0010, 32'h1122_3344, 4'hF);
    oku_t("tam_yaz", 32'h4000_0010, 32'h1122_3344, 2, 0);

    // Bytes 0 and 2 replaced
    yaz_t(32'h4000_0010, 32'hAABB_CCDD, 4'h5);
    oku_t("kismi_yaz", 32'h4000_0010, 32'h11BB_33DD, 2, 0);

    // Mask 0 leaves the word untouched
    yaz_t(32'h4000_0010, 32'hFFFF_FFFF, 4'h0);
    oku_t("maske_sifir", 32'h4000_0010, 32'h11BB_33DD, 2, 0);

    // Five stalled cycles in the response state
    oku_t("geri_basinc", 32'h4000_0010, 32'h11BB_33DD, 2, 5);

    // Out-of-range address 0x5000_0000
    yaz_t(32'h4000_0000, 32'h0BAD_F00D, 4'hF);
    @(negedge clk);
    bas = n_darbe;
    @(posedge clk); #1;
    yaz_t(32'h5000_0000, 32'h1234_5678, 4'hF);
`ifdef VERI_BELLEGI_ADRES_DENETIM_EN
    oku_t("disari_taban", 32'h4000_0000, 32'h0BAD_F00D, 2, 0);
    oku_t("disari_oku", 32'h5000_0000, 32'hDEAD_BEEF, 2, 0);
    kontrol("hata_darbe", n_darbe - bas, 2);
`else
    oku_t("sarma_taban", 32'h4000_0000, 32'h1234_5678, 2, 0);
    oku_t("sarma_oku", 32'h5000_0000, 32'h1234_5678, 2, 0);
    kontrol("hata_darbe", n_darbe - bas, 0);
`endif

    // Reset while counting latency
    yaz_t(32'h4000_0020, 32'hCAFE_0001, 4'hF);
    adres = 32'h4000_0020; yaz = 1'b0; a_gec = 1'b1;
    @(posedge clk); #1;
    a_gec = 1'b0;
    rst = 1'b1;
    #1;
    kontrol("sayda_reset_hazir", 32'(a_hazir), 1);
    kontrol("sayda_reset_gecerli", 32'(a_vgec), 0);
    kontrol("sayda_reset_veri", a_veri, 0);
    @(negedge clk);
    rst = 1'b0;
    gorulen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_vgec) gorulen++;
    end
    kontrol("sayda_reset_yanit_yok", gorulen, 0);
    @(posedge clk); #1;
    oku_t("reset_sonrasi", 32'h4000_0020, 32'hCAFE_0001, 2, 0);

    // Instance B: latency 1, four back-to-back writes
    sec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      adres = 32'h4000_0100 + 32'(4 * i);
      veri  = 32'hB000_0000 + 32'(i);
      maske = 4'hF; yaz = 1'b1; b_gec = 1'b1;
      @(negedge clk);
      kontrol("b_ardisik_yaz_hazir", 32'(b_hazir), 1);
      @(posedge clk); #1;
    end
    b_gec = 1'b0; yaz = 1'b0;
    oku_t("b_oku0", 32'h4000_0100, 32'hB000_0000, 1, 0);
    oku_t("b_oku3", 32'h4000_010C, 32'hB000_0003, 1, 2);

    $display("%0d/%0d checks passed", n_gecen, n_kontrol);
    $finish;
  end

endmodule
